// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the single-port memory arbiter that muxes
// instruction fetch and load/store traffic onto one backing memory port.
package mem_port_arbiter_pkg;

  typedef enum logic {
    MEM_PORT_IMEM = 1'b0,
    MEM_PORT_DMEM = 1'b1
  } e_mem_port;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE      = 2'd0,
    MEM_ARB_WAIT_IMEM = 2'd1,
    MEM_ARB_WAIT_DMEM = 2'd2
  } e_mem_arb_state;

  localparam int unsigned MEM_ARB_NUM_PORTS = 2;

  // Round-robin pick: a lone requester always wins; on a tie the port that
  // did not receive the previous grant goes first.
  function automatic e_mem_port mem_arb_pick(
    input logic      imem_valid,
    input logic      dmem_valid,
    input e_mem_port last_grant
  );
    e_mem_port pick;
    pick = MEM_PORT_IMEM;
    if (imem_valid && dmem_valid) begin
      if (last_grant == MEM_PORT_DMEM) begin
        pick = MEM_PORT_IMEM;
      end else begin
        pick = MEM_PORT_DMEM;
      end
    end else if (dmem_valid) begin
      pick = MEM_PORT_DMEM;
    end
    return pick;
  endfunction

  function automatic e_mem_arb_state mem_arb_wait_state(input e_mem_port port);
    e_mem_arb_state st;
    if (port == MEM_PORT_DMEM) begin
      st = MEM_ARB_WAIT_DMEM;
    end else begin
      st = MEM_ARB_WAIT_IMEM;
    end
    return st;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side handshake signals around the
// arbiter; slave is the arbiter's view, master is the core/memory view.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int FETCH_WIDTH = 64
);
  localparam int SIZE_WIDTH = $clog2(FETCH_WIDTH / 8);

  logic                   imem_rd_en_i;
  logic [DATA_WIDTH-1:0]  imem_addr_i;
  logic                   imem_busy_o;
  logic                   imem_rdy_o;
  logic [FETCH_WIDTH-1:0] imem_rd_data_o;

  logic                   dmem_rd_en_i;
  logic                   dmem_wr_en_i;
  logic [DATA_WIDTH-1:0]  dmem_addr_i;
  logic [SIZE_WIDTH-1:0]  dmem_wr_size_i;
  logic [FETCH_WIDTH-1:0] dmem_wr_data_i;
  logic                   dmem_busy_o;
  logic                   dmem_rdy_o;
  logic [FETCH_WIDTH-1:0] dmem_rd_data_o;

  logic                   mem_rd_en_o;
  logic                   mem_wr_en_o;
  logic [DATA_WIDTH-1:0]  mem_addr_o;
  logic [SIZE_WIDTH-1:0]  mem_wr_size_o;
  logic [FETCH_WIDTH-1:0] mem_wr_data_o;
  logic                   mem_busy_i;
  logic                   mem_rdy_i;
  logic [FETCH_WIDTH-1:0] mem_rd_data_i;

  modport slave (
    input  imem_rd_en_i, imem_addr_i,
    output imem_busy_o, imem_rdy_o, imem_rd_data_o,
    input  dmem_rd_en_i, dmem_wr_en_i, dmem_addr_i, dmem_wr_size_i, dmem_wr_data_i,
    output dmem_busy_o, dmem_rdy_o, dmem_rd_data_o,
    output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_size_o, mem_wr_data_o,
    input  mem_busy_i, mem_rdy_i, mem_rd_data_i
  );

  modport master (
    output imem_rd_en_i, imem_addr_i,
    input  imem_busy_o, imem_rdy_o, imem_rd_data_o,
    output dmem_rd_en_i, dmem_wr_en_i, dmem_addr_i, dmem_wr_size_i, dmem_wr_data_i,
    input  dmem_busy_o, dmem_rdy_o, dmem_rd_data_o,
    input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_size_o, mem_wr_data_o,
    output mem_busy_i, mem_rdy_i, mem_rd_data_i
  );

endinterface

// File: rtl/mem_port_arbiter_req_latch.sv
// One-entry request holding register: captures a request when empty and
// ignores further enables until the arbiter clears it on completion.
module mem_req_latch #(
  parameter int DATA_WIDTH  = 64,
  parameter int FETCH_WIDTH = 64,
  localparam int SIZE_WIDTH = $clog2(FETCH_WIDTH / 8)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  addr,
  input  logic [SIZE_WIDTH-1:0]  wr_size,
  input  logic [FETCH_WIDTH-1:0] wr_data,
  input  logic                   clr,
  output logic                   valid,
  output logic                   is_write,
  output logic [DATA_WIDTH-1:0]  held_addr,
  output logic [SIZE_WIDTH-1:0]  held_size,
  output logic [FETCH_WIDTH-1:0] held_data
);

  logic                   valid_reg;
  logic                   is_write_reg;
  logic [DATA_WIDTH-1:0]  addr_reg;
  logic [SIZE_WIDTH-1:0]  size_reg;
  logic [FETCH_WIDTH-1:0] data_reg;
  logic                   accept;

  // A simultaneous read+write enable is captured as a write.
  assign accept = (rd_en || wr_en) && !valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      is_write_reg <= 1'b0;
      addr_reg     <= '0;
      size_reg     <= '0;
      data_reg     <= '0;
    end else if (clr) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg    <= 1'b1;
      is_write_reg <= wr_en;
      addr_reg     <= addr;
      size_reg     <= wr_size;
      data_reg     <= wr_data;
    end
  end

  assign valid     = valid_reg;
  assign is_write  = is_write_reg;
  assign held_addr = addr_reg;
  assign held_size = size_reg;
  assign held_data = data_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store
// requesters; one transaction outstanding, issue driven from latched state.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int FETCH_WIDTH = 64
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int SIZE_WIDTH = $clog2(FETCH_WIDTH / 8);

  logic [MEM_ARB_NUM_PORTS-1:0] req_rd_en;
  logic [MEM_ARB_NUM_PORTS-1:0] req_wr_en;
  logic [DATA_WIDTH-1:0]        req_addr [MEM_ARB_NUM_PORTS];
  logic [SIZE_WIDTH-1:0]        req_size [MEM_ARB_NUM_PORTS];
  logic [FETCH_WIDTH-1:0]       req_data [MEM_ARB_NUM_PORTS];

  logic [MEM_ARB_NUM_PORTS-1:0] lat_clr;
  logic [MEM_ARB_NUM_PORTS-1:0] lat_valid;
  logic [MEM_ARB_NUM_PORTS-1:0] lat_is_write;
  logic [DATA_WIDTH-1:0]        lat_addr [MEM_ARB_NUM_PORTS];
  logic [SIZE_WIDTH-1:0]        lat_size [MEM_ARB_NUM_PORTS];
  logic [FETCH_WIDTH-1:0]       lat_data [MEM_ARB_NUM_PORTS];

  e_mem_arb_state state_reg, state_next;
  e_mem_port      last_grant_reg, last_grant_next;
  e_mem_port      winner;
  e_mem_port      sel_port;
  logic           sel_active;
  logic           issue_rd;
  logic           issue_wr;

  // Fetch never writes, so its latch write inputs are tied off.
  assign req_rd_en[MEM_PORT_IMEM] = bus.imem_rd_en_i;
  assign req_wr_en[MEM_PORT_IMEM] = 1'b0;
  assign req_addr[MEM_PORT_IMEM]  = bus.imem_addr_i;
  assign req_size[MEM_PORT_IMEM]  = '0;
  assign req_data[MEM_PORT_IMEM]  = '0;

  assign req_rd_en[MEM_PORT_DMEM] = bus.dmem_rd_en_i;
  assign req_wr_en[MEM_PORT_DMEM] = bus.dmem_wr_en_i;
  assign req_addr[MEM_PORT_DMEM]  = bus.dmem_addr_i;
  assign req_size[MEM_PORT_DMEM]  = bus.dmem_wr_size_i;
  assign req_data[MEM_PORT_DMEM]  = bus.dmem_wr_data_i;

  for (genvar gi = 0; gi < MEM_ARB_NUM_PORTS; gi++) begin : g_port
    logic                   rdy_reg;
    logic [FETCH_WIDTH-1:0] rd_data_reg;

    mem_req_latch #(
      .DATA_WIDTH (DATA_WIDTH),
      .FETCH_WIDTH(FETCH_WIDTH)
    ) u_latch (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (req_rd_en[gi]),
      .wr_en    (req_wr_en[gi]),
      .addr     (req_addr[gi]),
      .wr_size  (req_size[gi]),
      .wr_data  (req_data[gi]),
      .clr      (lat_clr[gi]),
      .valid    (lat_valid[gi]),
      .is_write (lat_is_write[gi]),
      .held_addr(lat_addr[gi]),
      .held_size(lat_size[gi]),
      .held_data(lat_data[gi])
    );

    // Completion pulse lands the cycle after mem_rdy_i; data holds until
    // this port's next completion.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdy_reg     <= 1'b0;
        rd_data_reg <= '0;
      end else begin
        rdy_reg <= lat_clr[gi];
        if (lat_clr[gi]) begin
          rd_data_reg <= bus.mem_rd_data_i;
        end
      end
    end
  end

  assign winner = mem_arb_pick(lat_valid[MEM_PORT_IMEM], lat_valid[MEM_PORT_DMEM],
                               last_grant_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= MEM_ARB_IDLE;
      last_grant_reg <= MEM_PORT_DMEM;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    sel_port        = MEM_PORT_IMEM;
    sel_active      = 1'b0;
    issue_rd        = 1'b0;
    issue_wr        = 1'b0;
    lat_clr         = '0;

    case (state_reg)
      MEM_ARB_IDLE: begin
        // Responses arriving here belong to nothing and are dropped.
        if (|lat_valid) begin
          sel_port   = winner;
          sel_active = 1'b1;
          if (!bus.mem_busy_i) begin
            issue_wr        = lat_is_write[winner];
            issue_rd        = !lat_is_write[winner];
            last_grant_next = winner;
            state_next      = mem_arb_wait_state(winner);
          end
        end
      end
      MEM_ARB_WAIT_IMEM: begin
        sel_port   = MEM_PORT_IMEM;
        sel_active = 1'b1;
        if (bus.mem_rdy_i) begin
          lat_clr[MEM_PORT_IMEM] = 1'b1;
          state_next             = MEM_ARB_IDLE;
        end
      end
      MEM_ARB_WAIT_DMEM: begin
        sel_port   = MEM_PORT_DMEM;
        sel_active = 1'b1;
        if (bus.mem_rdy_i) begin
          lat_clr[MEM_PORT_DMEM] = 1'b1;
          state_next             = MEM_ARB_IDLE;
        end
      end
      default: begin
        state_next = MEM_ARB_IDLE;
      end
    endcase
  end

  assign bus.mem_rd_en_o   = issue_rd;
  assign bus.mem_wr_en_o   = issue_wr;
  assign bus.mem_addr_o    = sel_active ? lat_addr[sel_port] : '0;
  assign bus.mem_wr_size_o = sel_active ? lat_size[sel_port] : '0;
  assign bus.mem_wr_data_o = sel_active ? lat_data[sel_port] : '0;

  assign bus.imem_busy_o    = lat_valid[MEM_PORT_IMEM];
  assign bus.dmem_busy_o    = lat_valid[MEM_PORT_DMEM];
  assign bus.imem_rdy_o     = g_port[0].rdy_reg;
  assign bus.dmem_rdy_o     = g_port[1].rdy_reg;
  assign bus.imem_rd_data_o = g_port[0].rd_data_reg;
  assign bus.dmem_rd_data_o = g_port[1].rd_data_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected issues and completions are
// queued as stimulus is driven and checked as the arbiter produces them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int DW = 64;
  localparam int FW = 64;
  localparam int SW = $clog2(FW / 8);

  typedef struct {
    e_mem_port     port;
    logic          is_write;
    logic [DW-1:0] addr;
    logic [SW-1:0] size;
    logic [FW-1:0] data;
  } iss_t;

  typedef struct {
    logic          chk_data;
    logic [FW-1:0] data;
  } cpl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  iss_t iss_q[$];
  cpl_t icpl_q[$];
  cpl_t dcpl_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_lat = 2;
  int   imem_rdy_cyc = -1;
  int   dmem_iss_cyc = -2;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FW-1:0] mem_data(input logic [DW-1:0] a);
    return a ^ 64'h0000_0000_0000_DFAD;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_iss(input e_mem_port p, input logic w, input logic [DW-1:0] a,
                          input logic [SW-1:0] s, input logic [FW-1:0] d);
    iss_t e;
    e.port = p; e.is_write = w; e.addr = a; e.size = s; e.data = d;
    iss_q.push_back(e);
  endtask

  // Memory model: answers each issue after mem_lat cycles with addr-derived data.
  logic [DW-1:0] resp_addr;
  logic          resp_wr;
  initial begin
    bus.mem_rdy_i     = 1'b0;
    bus.mem_rd_data_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.mem_rd_en_o || bus.mem_wr_en_o)) begin
        resp_addr = bus.mem_addr_o;
        resp_wr   = bus.mem_wr_en_o;
        repeat (mem_lat) @(posedge clk);
        #1;
        bus.mem_rdy_i     = 1'b1;
        bus.mem_rd_data_i = resp_wr ? '0 : mem_data(resp_addr);
        @(posedge clk);
        #1;
        bus.mem_rdy_i     = 1'b0;
        bus.mem_rd_data_i = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every issue and every completion pulse.
  iss_t mon_e;
  cpl_t mon_c;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_rd_en_o || bus.mem_wr_en_o) begin
          chk("issue_under_mem_busy", 64'(bus.mem_busy_i), 0);
          chk("issue_both_en", 64'(bus.mem_rd_en_o & bus.mem_wr_en_o), 0);
          chk("issue_expected", 64'(iss_q.size() != 0), 1);
          if (iss_q.size() != 0) begin
            mon_e = iss_q.pop_front();
            chk("issue_wr_en", 64'(bus.mem_wr_en_o), 64'(mon_e.is_write));
            chk("issue_addr", bus.mem_addr_o, mon_e.addr);
            if (mon_e.is_write) begin
              chk("issue_size", 64'(bus.mem_wr_size_o), 64'(mon_e.size));
              chk("issue_wdata", bus.mem_wr_data_o, mon_e.data);
            end
            mon_c.chk_data = !mon_e.is_write;
            mon_c.data     = mem_data(mon_e.addr);
            if (mon_e.port == MEM_PORT_DMEM) begin
              dcpl_q.push_back(mon_c);
              dmem_iss_cyc = cyc;
            end else begin
              icpl_q.push_back(mon_c);
            end
            $display("cyc %0d issue %s %s addr=%0h", cyc, mon_e.port.name(),
                     mon_e.is_write ? "wr" : "rd", bus.mem_addr_o);
          end
        end
        if (bus.imem_rdy_o) begin
          imem_rdy_cyc = cyc;
          chk("imem_busy_at_rdy", 64'(bus.imem_busy_o), 0);
          chk("imem_rdy_expected", 64'(icpl_q.size() != 0), 1);
          if (icpl_q.size() != 0) begin
            mon_c = icpl_q.pop_front();
            chk("imem_rd_data", bus.imem_rd_data_o, mon_c.data);
          end
          $display("cyc %0d imem done data=%0h", cyc, bus.imem_rd_data_o);
        end
        if (bus.dmem_rdy_o) begin
          chk("dmem_busy_at_rdy", 64'(bus.dmem_busy_o), 0);
          chk("dmem_rdy_expected", 64'(dcpl_q.size() != 0), 1);
          if (dcpl_q.size() != 0) begin
            mon_c = dcpl_q.pop_front();
            if (mon_c.chk_data) chk("dmem_rd_data", bus.dmem_rd_data_o, mon_c.data);
          end
          $display("cyc %0d dmem done data=%0h", cyc, bus.dmem_rd_data_o);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.imem_rd_en_i   = 1'b0;
    bus.dmem_rd_en_i   = 1'b0;
    bus.dmem_wr_en_i   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((iss_q.size() != 0 || icpl_q.size() != 0 || dcpl_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 64'(n < 300), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ni, nd;
    clear_inputs();
    bus.imem_addr_i    = '0;
    bus.dmem_addr_i    = '0;
    bus.dmem_wr_size_i = '0;
    bus.dmem_wr_data_i = '0;
    bus.mem_busy_i     = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_imem_busy", 64'(bus.imem_busy_o), 0);
    chk("rst_dmem_busy", 64'(bus.dmem_busy_o), 0);
    chk("rst_imem_rdy", 64'(bus.imem_rdy_o), 0);
    chk("rst_dmem_rdy", 64'(bus.dmem_rdy_o), 0);
    chk("rst_mem_rd_en", 64'(bus.mem_rd_en_o), 0);
    chk("rst_mem_wr_en", 64'(bus.mem_wr_en_o), 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_wr_size", 64'(bus.mem_wr_size_o), 0);
    chk("rst_mem_wr_data", bus.mem_wr_data_o, 0);
    chk("rst_imem_rd_data", bus.imem_rd_data_o, 0);
    chk("rst_dmem_rd_data", bus.dmem_rd_data_o, 0);

    // Single imem read, cycle-exact
    @(posedge clk); #1;
    bus.imem_rd_en_i = 1'b1;
    bus.imem_addr_i  = 64'h100;
    push_iss(MEM_PORT_IMEM, 1'b0, 64'h100, '0, '0);
    @(negedge clk);
    chk("t1_busy_c0", 64'(bus.imem_busy_o), 0);
    @(posedge clk); #1;
    bus.imem_rd_en_i = 1'b0;
    @(negedge clk);
    chk("t1_busy_c1", 64'(bus.imem_busy_o), 1);
    chk("t1_rd_en_c1", 64'(bus.mem_rd_en_o), 1);
    chk("t1_addr_c1", bus.mem_addr_o, 64'h100);
    @(negedge clk);
    chk("t1_busy_c2", 64'(bus.imem_busy_o), 1);
    chk("t1_rd_en_c2", 64'(bus.mem_rd_en_o), 0);
    @(negedge clk);
    chk("t1_busy_c3", 64'(bus.imem_busy_o), 1);
    chk("t1_rdy_c3", 64'(bus.imem_rdy_o), 0);
    @(negedge clk);
    chk("t1_rdy_c4", 64'(bus.imem_rdy_o), 1);
    chk("t1_busy_c4", 64'(bus.imem_busy_o), 0);
    chk("t1_data_c4", bus.imem_rd_data_o, 64'hDEAD);
    @(negedge clk);
    chk("t1_rdy_c5", 64'(bus.imem_rdy_o), 0);
    chk("t1_data_hold", bus.imem_rd_data_o, 64'hDEAD);
    wait_idle("t1");

    // Tie after reset: imem first, dmem write on the first IDLE after it
    do_reset();
    @(posedge clk); #1;
    bus.imem_rd_en_i   = 1'b1;
    bus.imem_addr_i    = 64'h0;
    bus.dmem_wr_en_i   = 1'b1;
    bus.dmem_addr_i    = 64'h40;
    bus.dmem_wr_data_i = 64'hBEEF;
    bus.dmem_wr_size_i = 3'd3;
    push_iss(MEM_PORT_IMEM, 1'b0, 64'h0, '0, '0);
    push_iss(MEM_PORT_DMEM, 1'b1, 64'h40, 3'd3, 64'hBEEF);
    @(posedge clk); #1;
    clear_inputs();
    wait_idle("t2");
    chk("t2_dmem_issue_cycle", 64'(dmem_iss_cyc), 64'(imem_rdy_cyc));

    // Continuous contention: grants must alternate imem, dmem, ...
    @(posedge clk); #1;
    bus.imem_rd_en_i = 1'b1;
    bus.imem_addr_i  = 64'h1000;
    bus.dmem_rd_en_i = 1'b1;
    bus.dmem_addr_i  = 64'h2000;
    push_iss(MEM_PORT_IMEM, 1'b0, 64'h1000, '0, '0);
    push_iss(MEM_PORT_DMEM, 1'b0, 64'h2000, '0, '0);
    ni = 1;
    nd = 1;
    n  = 0;
    @(posedge clk); #1;
    clear_inputs();
    while ((ni < 4 || nd < 4 || iss_q.size() != 0 || icpl_q.size() != 0 ||
            dcpl_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
      clear_inputs();
      if (bus.imem_rdy_o && ni < 4) begin
        bus.imem_rd_en_i = 1'b1;
        bus.imem_addr_i  = 64'h1000 + 64'(ni * 8);
        push_iss(MEM_PORT_IMEM, 1'b0, bus.imem_addr_i, '0, '0);
        ni++;
      end
      if (bus.dmem_rdy_o && nd < 4) begin
        bus.dmem_addr_i    = 64'h2000 + 64'(nd * 8);
        bus.dmem_wr_size_i = 3'(nd);
        bus.dmem_wr_data_i = 64'hC0DE_0000 + 64'(nd);
        if (nd % 2 == 1) begin
          bus.dmem_wr_en_i = 1'b1;
          push_iss(MEM_PORT_DMEM, 1'b1, bus.dmem_addr_i, bus.dmem_wr_size_i, bus.dmem_wr_data_i);
        end else begin
          bus.dmem_rd_en_i = 1'b1;
          push_iss(MEM_PORT_DMEM, 1'b0, bus.dmem_addr_i, '0, '0);
        end
        nd++;
      end
    end
    chk("t3_completed", 64'(n < 400), 1);
    clear_inputs();
    repeat (3) @(negedge clk);

    // Memory back-pressure holds off the issue
    @(posedge clk); #1;
    bus.mem_busy_i   = 1'b1;
    bus.dmem_rd_en_i = 1'b1;
    bus.dmem_addr_i  = 64'h3000;
    push_iss(MEM_PORT_DMEM, 1'b0, 64'h3000, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_off", 64'(bus.mem_rd_en_o | bus.mem_wr_en_o), 0);
      @(posedge clk); #1;
      bus.dmem_rd_en_i = 1'b0;
    end
    bus.mem_busy_i = 1'b0;
    @(negedge clk);
    chk("t4_issue_on_release", 64'(bus.mem_rd_en_o), 1);
    @(negedge clk);
    chk("t4_single_pulse", 64'(bus.mem_rd_en_o | bus.mem_wr_en_o), 0);
    wait_idle("t4");

    // Reset while waiting on a dmem load; the late response must be dropped
    mem_lat = 6;
    @(posedge clk); #1;
    bus.dmem_rd_en_i = 1'b1;
    bus.dmem_addr_i  = 64'h4000;
    push_iss(MEM_PORT_DMEM, 1'b0, 64'h4000, '0, '0);
    @(posedge clk); #1;
    clear_inputs();
    n = 0;
    while (!bus.mem_rd_en_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_issued", 64'(n < 20), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    iss_q.delete();
    icpl_q.delete();
    dcpl_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_no_dmem_rdy", 64'(bus.dmem_rdy_o), 0);
      chk("t5_dmem_busy", 64'(bus.dmem_busy_o), 0);
      chk("t5_imem_busy", 64'(bus.imem_busy_o), 0);
    end
    mem_lat = 2;
    @(posedge clk); #1;
    bus.imem_rd_en_i = 1'b1;
    bus.imem_addr_i  = 64'h5000;
    push_iss(MEM_PORT_IMEM, 1'b0, 64'h5000, '0, '0);
    @(posedge clk); #1;
    clear_inputs();
    wait_idle("t5");

    // Combined read+write is a write; en while busy is ignored
    mem_lat = 4;
    @(posedge clk); #1;
    bus.dmem_rd_en_i   = 1'b1;
    bus.dmem_wr_en_i   = 1'b1;
    bus.dmem_addr_i    = 64'h80;
    bus.dmem_wr_data_i = 64'h1234;
    bus.dmem_wr_size_i = 3'd2;
    push_iss(MEM_PORT_DMEM, 1'b1, 64'h80, 3'd2, 64'h1234);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("t6_no_rd_en", 64'(bus.mem_rd_en_o), 0);
    chk("t6_wr_en", 64'(bus.mem_wr_en_o), 1);
    @(posedge clk); #1;
    bus.dmem_rd_en_i   = 1'b1;
    bus.dmem_addr_i    = 64'h999;
    bus.dmem_wr_data_i = 64'h5555;
    bus.dmem_wr_size_i = 3'd1;
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("t6_addr_hold", bus.mem_addr_o, 64'h80);
    chk("t6_wdata_hold", bus.mem_wr_data_o, 64'h1234);
    chk("t6_size_hold", 64'(bus.mem_wr_size_o), 2);
    chk("t6_busy_held", 64'(bus.dmem_busy_o), 1);
    wait_idle("t6");
    chk("t6_idle_after", 64'(bus.dmem_busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
